gcd_req_master: RTL and testbench
=================================

Name: gcd_req_master

Overview:
- Upstream driver for gcd_top. Takes a complete operand pair (A, B) on a valid/ready interface and sequences the two-phase four-wire req/ack protocol that gcd_top expects: A, then B.
- Captures C when the second ack arrives and presents the result with its operands on a valid/ready output.
- Lets a processor or stream source use the GCD core without cycle-level protocol handling.
- A watchdog flags a core that stops responding.

Parameters:
- W, 16, operand/result width; must match gcd_top AB/C width.
- TIMEOUT, 1024, max cycles spent in any ack-wait state before error; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair available.
- in_ready  out  1  block can accept a pair.
- in_a  in  W  first operand.
- in_b  in  W  second operand.
- req  out  1  request to gcd_top.
- AB  out  W  operand bus to gcd_top.
- ack  in  1  acknowledge from gcd_top.
- C  in  W  result from gcd_top; valid while ack=1 in the B phase.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_c  out  W  gcd result.
- out_a  out  W  echo of A.
- out_b  out  W  echo of B.
- err  out  1  sticky watchdog timeout flag.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. Ports are named clk and reset.
- Registered outputs: all outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- Reset values (state IDLE):
  - req=0, AB=0, out_valid=0, out_c/out_a/out_b=0, err=0, in_ready=1.
  - Watchdog counter = 0.
- FSM states: IDLE, A_HI, A_LO, B_HI, B_LO, OUT, ERR. Transitions below are evaluated on the rising edge; outputs change after that edge.
- IDLE:
  - in_ready=1, req=0.
  - On in_valid=1: latch in_a/in_b, drive AB<=in_a and req<=1, go to A_HI.
- A_HI:
  - req=1, AB=A.
  - On ack=1: req<=0, go to A_LO.
- A_LO:
  - req=0.
  - On ack=0: AB<=B, req<=1, go to B_HI.
  - AB changes in the same edge as req rises, so B is stable whenever req=1.
- B_HI:
  - req=1, AB=B.
  - On ack=1: out_c<=C (sampled at this edge), req<=0, go to B_LO.
- B_LO:
  - req=0.
  - On ack=0: out_valid<=1, go to OUT.
- OUT:
  - out_valid=1; out_c/out_a/out_b held stable.
  - On out_ready=1: out_valid<=0, go to IDLE.
  - in_ready=0 throughout; there is no overlap with the next pair.
- Latency:
  - Pair accepted at edge k gives req=1 after edge k.
  - With an ideal single-cycle responder, the minimum is 4 protocol round trips. out_valid appears ≥8 cycles after acceptance.
- Watchdog:
  - Counter clears on every state change and increments each cycle in A_HI, A_LO, B_HI and B_LO.
  - When it reaches TIMEOUT (and TIMEOUT≠0): go to ERR next edge.
- ERR:
  - req=0, in_ready=0, out_valid=0, err=1.
  - Leaves only on reset.
- Boundary conditions:
  - ack already 1 on entry to A_HI/B_HI is a protocol violation. The block still advances; the bench never does this.
  - in_valid while not IDLE is ignored; in_ready=0.
  - Operand values 0 are passed through unmodified; no check is made.
  - reset in any state, including mid-handshake: IDLE next edge, req=0 next cycle, pending pair discarded, err cleared.
  - out_ready held high before out_valid: the result is consumed in the first OUT cycle (one-cycle out_valid pulse).

Decomposition:
- Package gcd_pkg:
  - typedef enum of the FSM states.
  - default W and TIMEOUT localparams.
  - typedef struct {a, b, c} gcd_result_t, used by out_*.
- Sub-module gcd_watchdog: counter, clear, enable and expired outputs, parameterised by TIMEOUT.
- The FSM stays in gcd_req_master.

Test Plan:
- DUT connected to real gcd_top (n=2). Pairs (25,5), (29232,488), (49,98), (32768,272), (91,63), out_ready=1 -> out_c = 5, 8, 49, 16, 7 respectively, with out_a/out_b echoed. AB=A only while in A_HI and AB=B only while in B_HI. err=0.
- Backpressure: pair (91,63), out_ready=0 for 20 cycles -> out_valid stays 1 and out_c=7 stable. in_ready=0 until the cycle after out_ready=1.
- Protocol checker, behavioural responder with random 0–5 cycle ack delays -> req never rises while ack=1; AB stable for whole req=1 interval; four req pulse edges (two rises, two falls) per pair.
- Timeout: TIMEOUT=8, responder never asserts ack -> err=1 exactly 8 cycles after entering A_HI, req=0, in_ready=0. Reset then gives err=0, in_ready=1.
- Mid-operation reset: reset asserted for 1 cycle while in B_HI -> req=0 and state IDLE after that edge, out_valid never asserted. A following pair (25,5) -> 5.
- Back-to-back: in_valid held high with 3 queued pairs -> each pair accepted exactly once, results in order, no dropped or duplicated transfers.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd_top request master.
// Widths here set the default operand/result width of the block.
package gcd_pkg;

    localparam int GCD_W       = 16;
    localparam int GCD_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        A_HI,
        A_LO,
        B_HI,
        B_LO,
        OUT,
        ERR
    } gcd_state_e;

    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
        logic [GCD_W-1:0] c;
    } gcd_result_t;

endpackage

// File: rtl/gcd_watchdog.sv
// Cycle counter that flags a stalled handshake partner.
// Expiry is raised on the cycle the count would reach TIMEOUT.
module gcd_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam logic ARMED = (TIMEOUT != 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = ARMED && en && (cnt == LAST);

endmodule

// File: rtl/gcd_req_master.sv
// Valid/ready front end that runs the two-phase req/ack sequence
// (A then B) against gcd_top and returns C with its operands.
module gcd_req_master
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         req,
    output logic [W-1:0] AB,
    input  logic         ack,
    input  logic [W-1:0] C,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_c,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic         err
);

    if (W != GCD_W) begin : g_w_chk
        $error("gcd_req_master: W must equal GCD_W");
    end

    gcd_state_e  state;
    gcd_state_e  nxt;
    gcd_result_t res_q;
    logic [W-1:0] ab_q;

    logic accept;
    logic load_b;
    logic cap_c;
    logic wd_en;
    logic wd_clr;
    logic expired;

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        load_b = 1'b0;
        cap_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    nxt    = A_HI;
                    accept = 1'b1;
                end
            end
            A_HI: begin
                if (expired)  nxt = ERR;
                else if (ack) nxt = A_LO;
            end
            A_LO: begin
                if (expired) begin
                    nxt = ERR;
                end else if (!ack) begin
                    nxt    = B_HI;
                    load_b = 1'b1;
                end
            end
            B_HI: begin
                if (expired) begin
                    nxt = ERR;
                end else if (ack) begin
                    nxt   = B_LO;
                    cap_c = 1'b1;
                end
            end
            B_LO: begin
                if (expired)   nxt = ERR;
                else if (!ack) nxt = OUT;
            end
            OUT: begin
                if (out_ready) nxt = IDLE;
            end
            ERR: begin
                nxt = ERR;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // AB is loaded on the same edge req rises, so it is stable while req=1
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ab_q  <= '0;
            res_q <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                ab_q    <= in_a;
                res_q.a <= in_a;
                res_q.b <= in_b;
            end
            if (load_b) ab_q    <= res_q.b;
            if (cap_c)  res_q.c <= C;
        end
    end

    assign wd_en  = (state == A_HI) || (state == A_LO) ||
                    (state == B_HI) || (state == B_LO);
    assign wd_clr = (nxt != state);

    gcd_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(expired)
    );

    assign in_ready  = (state == IDLE);
    assign req       = (state == A_HI) || (state == B_HI);
    assign out_valid = (state == OUT);
    assign err       = (state == ERR);
    assign AB        = ab_q;
    assign out_a     = res_q.a;
    assign out_b     = res_q.b;
    assign out_c     = res_q.c;

endmodule

// File: tb/tb_gcd_req_master.sv
// Bench for gcd_req_master with a behavioural four-phase responder,
// a protocol monitor and a result scoreboard.
module tb_gcd_req_master;

    localparam int W  = 16;
    localparam int TO = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         req;
    logic [W-1:0] AB;
    logic         ack = 1'b0;
    logic [W-1:0] C = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_c;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int maxd = 0;
    logic mute = 1'b0;

    exp_t         exp_q[$];
    logic [W-1:0] ab_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_req_master #(
        .W(W),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .req      (req),
        .AB       (AB),
        .ack      (ack),
        .C        (C),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_c    (out_c),
        .out_a    (out_a),
        .out_b    (out_b),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] gcd(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        logic [W-1:0] p = x;
        logic [W-1:0] q = y;
        logic [W-1:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Behavioural gcd_top: random ack delays, C valid in the B phase
    int           dly = 0;
    logic         phase_b = 1'b0;
    logic [W-1:0] ra = '0;

    always @(posedge clk) begin
        if (reset || mute) begin
            ack     <= 1'b0;
            dly     <= 0;
            phase_b <= 1'b0;
        end else if (!ack && req) begin
            if (dly == 0) begin
                ack <= 1'b1;
                if (phase_b) C <= gcd(ra, AB);
                else         ra <= AB;
                dly <= int'($urandom_range(maxd, 0));
            end else begin
                dly <= dly - 1;
            end
        end else if (ack && !req) begin
            if (dly == 0) begin
                ack     <= 1'b0;
                phase_b <= ~phase_b;
                dly     <= int'($urandom_range(maxd, 0));
            end else begin
                dly <= dly - 1;
            end
        end
    end

    // Protocol monitor and output scoreboard
    logic         req_p = 1'b0;
    logic [W-1:0] ab_p = '0;
    bit           ab_chg = 1'b0;
    bit           skip = 1'b0;
    int           rises = 0;
    int           falls = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            ab_q.delete();
            rises  = 0;
            falls  = 0;
            ab_chg = 1'b0;
            skip   = 1'b1;
        end else if (skip) begin
            skip = 1'b0;
        end else begin
            if (req && !req_p) begin
                rises++;
                chk("req_rise_ack", 32'(ack), 0);
                if (ab_q.size() == 0) chk("ab_unexpected", 1, 0);
                else chk("ab_value", 32'(AB), 32'(ab_q.pop_front()));
            end
            if (req && req_p && AB != ab_p) ab_chg = 1'b1;
            if (!req && req_p) begin
                falls++;
                chk("ab_stable", 32'(ab_chg), 0);
                ab_chg = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_c", 32'(out_c), 32'(e.c));
                    chk("out_a", 32'(out_a), 32'(e.a));
                    chk("out_b", 32'(out_b), 32'(e.b));
                end
                chk("req_rises", rises, 2);
                chk("req_falls", falls, 2);
                rises = 0;
                falls = 0;
            end
        end
        req_p = req;
        ab_p  = AB;
    end

    // Inputs are driven 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
        exp_t e;
        int   n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.a = a;
        e.b = b;
        e.c = c;
        exp_q.push_back(e);
        ab_q.push_back(a);
        ab_q.push_back(b);
        tick();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(exp_q.size() == 0 && in_ready) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("done_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [W-1:0] pa[5] = '{16'd25, 16'd29232, 16'd49, 16'd32768, 16'd91};
    logic [W-1:0] pb[5] = '{16'd5, 16'd488, 16'd98, 16'd272, 16'd63};
    logic [W-1:0] pc[5] = '{16'd5, 16'd8, 16'd49, 16'd16, 16'd7};

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [W-1:0] ra2;
        logic [W-1:0] rb2;
        int n;
        int c0;
        int c1;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) tick();

        chk("rst_req", 32'(req), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ab", 32'(AB), 0);
        chk("rst_out_c", 32'(out_c), 0);
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_out_b", 32'(out_b), 0);
        reset = 1'b0;
        tick();

        maxd = 0;
        for (int i = 0; i < 5; i++) begin
            send(pa[i], pb[i], pc[i]);
            in_valid = 1'b0;
            wait_done();
        end

        maxd = 5;
        send(16'd0, 16'd0, 16'd0);
        in_valid = 1'b0;
        send(16'd0, 16'd12, 16'd12);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ra2 = W'($urandom_range(65535, 1));
            rb2 = W'($urandom_range(65535, 1));
            send(ra2, rb2, gcd(ra2, rb2));
            in_valid = 1'b0;
        end
        wait_done();
        chk("err_clean", 32'(err), 0);

        out_ready = 1'b0;
        send(16'd91, 16'd63, 16'd7);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("bp_out_valid_seen", 32'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_c", 32'(out_c), 7);
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_in_ready_hold", 32'(in_ready), 0);
        tick();
        chk("bp_in_ready_back", 32'(in_ready), 1);
        chk("bp_out_valid_drop", 32'(out_valid), 0);

        for (int i = 0; i < 3; i++) begin
            ra2 = W'($urandom_range(4000, 1));
            rb2 = W'($urandom_range(4000, 1));
            send(ra2, rb2, gcd(ra2, rb2));
        end
        in_valid = 1'b0;
        wait_done();

        maxd = 3;
        send(16'd40, 16'd24, 16'd8);
        in_valid = 1'b0;
        n = 0;
        while (rises < 2 && n < 100) begin
            tick();
            n++;
        end
        chk("mid_reached_b_hi", 32'(req), 1);
        pulse_reset();
        chk("mid_req", 32'(req), 0);
        chk("mid_in_ready", 32'(in_ready), 1);
        chk("mid_out_valid", 32'(out_valid), 0);
        tick();
        send(16'd25, 16'd5, 16'd5);
        in_valid = 1'b0;
        wait_done();

        mute = 1'b1;
        send(16'd12, 16'd8, 16'd4);
        in_valid = 1'b0;
        c0 = cyc;
        chk("wd_req_high", 32'(req), 1);
        n = 0;
        while (!err && n < 50) begin
            tick();
            n++;
        end
        c1 = cyc;
        chk("wd_err", 32'(err), 1);
        chk("wd_cycles", c1 - c0, TO);
        chk("wd_req", 32'(req), 0);
        chk("wd_in_ready", 32'(in_ready), 0);
        chk("wd_out_valid", 32'(out_valid), 0);
        repeat (3) tick();
        chk("wd_sticky", 32'(err), 1);
        pulse_reset();
        mute = 1'b0;
        chk("wd_rst_err", 32'(err), 0);
        chk("wd_rst_in_ready", 32'(in_ready), 1);

        maxd = 2;
        send(16'd91, 16'd63, 16'd7);
        in_valid = 1'b0;
        wait_done();
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
